// File: rtl/sequence_stream_checker_if.sv
// ----------------------------------------------------------------------------
// sequence_stream_checker_if
//   Sample stream carried from a number generator (Fibonacci, Collatz,
//   stopwatch) to the receive-side checker.
//   Signals:
//     Valid  one-cycle strobe marking a new sample
//     Data   W-bit sample value, meaningful only while Valid is high
//   Modports:
//     master  the side that produces samples (generator or testbench)
//     slave   the side that consumes samples (sequence_stream_checker)
// ----------------------------------------------------------------------------
interface sequence_stream_checker_if #(
    parameter int W = 16
) ();

    logic         Valid;
    logic [W-1:0] Data;

    modport master (
        output Valid,
        output Data
    );

    modport slave (
        input Valid,
        input Data
    );

endinterface : sequence_stream_checker_if

// File: rtl/sequence_stream_checker.sv
// ----------------------------------------------------------------------------
// sequence_stream_checker
//   Receive-side checker for the 16-bit number stream that feeds the
//   7-segment display path. Each sample is compared against a locally
//   predicted value. The prediction for the following sample is always
//   rebuilt from the received data, so the checker re-locks onto the stream
//   by itself after a corrupt sample.
//
//   Parameters:
//     MODE        0 = Fibonacci, 1 = Collatz, 2 = stopwatch (MM.SS, 0..9959)
//     SEED_0      Fibonacci implicit predecessor of the first sample
//     SEED_1      Fibonacci first sample
//     SEED        Collatz first sample
//     RESET_WHEN  stopwatch wrap value
//     W           data width; all arithmetic wraps modulo 2^W
//
//   Ports:
//     Clk            clock
//     Rst            asynchronous active-high reset
//     Clr            synchronous restart, same effect as Rst; beats Valid
//     stream         slave side of the sample stream (Valid, Data)
//     Expected       value predicted for the next sample
//     MatchPulse     one-cycle pulse, the cycle after a matching sample
//     MismatchPulse  one-cycle pulse, the cycle after a mismatching sample
//     ErrLatched     sticky flag: any mismatch since reset/Clr
//     SampleCnt      accepted samples, saturating at 16'hFFFF
//     ErrCnt         mismatching samples, saturating at 16'hFFFF
//     Done           Collatz only: a sample equal to 1 has been seen
//     State          FSM state (0 IDLE, 1 RUN, 2 RESYNC)
// ----------------------------------------------------------------------------
module sequence_stream_checker #(
    parameter int MODE       = 0,
    parameter int SEED_0     = 0,
    parameter int SEED_1     = 1,
    parameter int SEED       = 27,
    parameter int RESET_WHEN = 9959,
    parameter int W          = 16
) (
    input  logic                            Clk,
    input  logic                            Rst,
    input  logic                            Clr,
    sequence_stream_checker_if.slave        stream,
    output logic [W-1:0]                    Expected,
    output logic                            MatchPulse,
    output logic                            MismatchPulse,
    output logic                            ErrLatched,
    output logic [15:0]                     SampleCnt,
    output logic [15:0]                     ErrCnt,
    output logic                            Done,
    output logic [1:0]                      State
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [W-1:0] ZERO_W       = W'(0);
    localparam logic [W-1:0] ONE_W        = W'(1);
    localparam logic [W-1:0] HUNDRED_W    = W'(100);
    localparam logic [W-1:0] SEC_LAST_W   = W'(59);
    localparam logic [W-1:0] WRAP_W       = W'(RESET_WHEN);
    localparam logic [W-1:0] PREV_RST_W   = W'(SEED_0);
    localparam logic [15:0]  CNT_MAX      = 16'hFFFF;

    // First prediction after reset depends on which generator is watched.
    localparam logic [W-1:0] EXP_RST_W =
        (MODE == 0) ? W'(SEED_1) :
        (MODE == 1) ? W'(SEED)   : ZERO_W;

    // ------------------------------------------------------------------
    // Next-value helpers; each takes the received sample x.
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] fib_next(input logic [W-1:0] x,
                                              input logic [W-1:0] prev);
        return x + prev;
    endfunction

    function automatic logic [W-1:0] collatz_next(input logic [W-1:0] x);
        logic [W-1:0] r;
        if (x <= ONE_W) begin
            r = ONE_W;
        end else if (x[0] == 1'b0) begin
            r = {1'b0, x[W-1:1]};
        end else begin
            // 3x+1 as 2x + x + 1; overflow wraps silently
            r = {x[W-2:0], 1'b0} + x + ONE_W;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] stopwatch_next(input logic [W-1:0] x);
        logic [W-1:0] r;
        if (x >= WRAP_W) begin
            r = ZERO_W;
        end else if ((x % HUNDRED_W) >= SEC_LAST_W) begin
            // seconds roll over: next whole minute
            r = ((x / HUNDRED_W) + ONE_W) * HUNDRED_W;
        end else begin
            r = x + ONE_W;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    state_t         state_r;
    state_t         state_next_s;
    logic [W-1:0]   expected_r;
    logic [W-1:0]   expected_next_s;
    logic [W-1:0]   prev_r;
    logic [W-1:0]   prev_next_s;
    logic           match_pulse_r;
    logic           match_pulse_next_s;
    logic           mismatch_pulse_r;
    logic           mismatch_pulse_next_s;
    logic           err_latched_r;
    logic           err_latched_next_s;
    logic [15:0]    sample_cnt_r;
    logic [15:0]    sample_cnt_next_s;
    logic [15:0]    err_cnt_r;
    logic [15:0]    err_cnt_next_s;
    logic           done_r;
    logic           done_next_s;

    logic           sample_s;
    logic           match_s;
    logic [W-1:0]   data_s;

    // A sample coinciding with Clr is dropped.
    assign data_s   = stream.Data;
    assign sample_s = stream.Valid & ~Clr;
    assign match_s  = (data_s == expected_r);

    // FSM state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        if (Clr) begin
            state_next_s = ST_IDLE;
        end else if (sample_s) begin
            case (state_r)
                ST_IDLE:   state_next_s = ST_RUN;
                ST_RUN:    state_next_s = match_s ? ST_RUN : ST_RESYNC;
                ST_RESYNC: state_next_s = match_s ? ST_RUN : ST_RESYNC;
                default:   state_next_s = ST_IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Prediction: always derived from the received sample, never the old guess
    always_comb begin
        expected_next_s = expected_r;
        prev_next_s     = prev_r;
        if (Clr) begin
            expected_next_s = EXP_RST_W;
            prev_next_s     = PREV_RST_W;
        end else if (sample_s) begin
            case (MODE)
                0: begin
                    expected_next_s = fib_next(data_s, prev_r);
                    prev_next_s     = data_s;
                end
                1:       expected_next_s = collatz_next(data_s);
                2:       expected_next_s = stopwatch_next(data_s);
                default: expected_next_s = expected_r;
            endcase
        end else begin
            expected_next_s = expected_r;
            prev_next_s     = prev_r;
        end
    end

    // Result pulses, saturating counters and sticky flags
    always_comb begin
        match_pulse_next_s    = 1'b0;
        mismatch_pulse_next_s = 1'b0;
        err_latched_next_s    = err_latched_r;
        sample_cnt_next_s     = sample_cnt_r;
        err_cnt_next_s        = err_cnt_r;
        done_next_s           = done_r;
        if (Clr) begin
            err_latched_next_s = 1'b0;
            sample_cnt_next_s  = 16'd0;
            err_cnt_next_s     = 16'd0;
            done_next_s        = 1'b0;
        end else if (sample_s) begin
            match_pulse_next_s    = match_s;
            mismatch_pulse_next_s = ~match_s;
            if (sample_cnt_r != CNT_MAX) begin
                sample_cnt_next_s = sample_cnt_r + 16'd1;
            end else begin
                sample_cnt_next_s = sample_cnt_r;
            end
            if (!match_s) begin
                err_latched_next_s = 1'b1;
                if (err_cnt_r != CNT_MAX) begin
                    err_cnt_next_s = err_cnt_r + 16'd1;
                end else begin
                    err_cnt_next_s = err_cnt_r;
                end
            end else begin
                err_latched_next_s = err_latched_r;
                err_cnt_next_s     = err_cnt_r;
            end
            if ((MODE == 1) && (data_s == ONE_W)) begin
                done_next_s = 1'b1;
            end else begin
                done_next_s = done_r;
            end
        end else begin
            match_pulse_next_s    = 1'b0;
            mismatch_pulse_next_s = 1'b0;
        end
    end

    // Datapath and bookkeeping registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            expected_r       <= EXP_RST_W;
            prev_r           <= PREV_RST_W;
            match_pulse_r    <= 1'b0;
            mismatch_pulse_r <= 1'b0;
            err_latched_r    <= 1'b0;
            sample_cnt_r     <= 16'd0;
            err_cnt_r        <= 16'd0;
            done_r           <= 1'b0;
        end else begin
            expected_r       <= expected_next_s;
            prev_r           <= prev_next_s;
            match_pulse_r    <= match_pulse_next_s;
            mismatch_pulse_r <= mismatch_pulse_next_s;
            err_latched_r    <= err_latched_next_s;
            sample_cnt_r     <= sample_cnt_next_s;
            err_cnt_r        <= err_cnt_next_s;
            done_r           <= done_next_s;
        end
    end

    // Outputs come straight from registers
    assign Expected      = expected_r;
    assign MatchPulse    = match_pulse_r;
    assign MismatchPulse = mismatch_pulse_r;
    assign ErrLatched    = err_latched_r;
    assign SampleCnt     = sample_cnt_r;
    assign ErrCnt        = err_cnt_r;
    assign Done          = done_r;
    assign State         = state_r;

endmodule : sequence_stream_checker
